// File: rtl/reservation_station_multi_if.sv
// Bus bundle for reservation_station_multi: allocation, CDB snoop, FU issue and status.
// master drives allocation/CDB/flush/alu_free; slave is the reservation station.
interface reservation_station_multi_if #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 8,
  parameter int NUM_CDB = 1
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                      flush;
  logic                      load_word;
  logic [OP_W-1:0]           control_word;
  logic [TAG_W-1:0]          dest_tag;
  logic [DATA_W-1:0]         src1;
  logic                      rob_v1;
  logic [TAG_W-1:0]          rob_tag1;
  logic [DATA_W-1:0]         src2;
  logic                      rob_v2;
  logic [TAG_W-1:0]          rob_tag2;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic                      alu_free;
  logic                      start_exe;
  logic [OP_W-1:0]           alu_op;
  logic [TAG_W-1:0]          alu_tag;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic                      res_full;
  logic                      res_empty;
  logic [CNT_W-1:0]          occupancy;

  modport master (
    output flush, load_word, control_word, dest_tag,
           src1, rob_v1, rob_tag1, src2, rob_v2, rob_tag2,
           cdb_valid, cdb_tag, cdb_data, alu_free,
    input  start_exe, alu_op, alu_tag, alu_a, alu_b,
           res_full, res_empty, occupancy
  );

  modport slave (
    input  flush, load_word, control_word, dest_tag,
           src1, rob_v1, rob_tag1, src2, rob_v2, rob_tag2,
           cdb_valid, cdb_tag, cdb_data, alu_free,
    output start_exe, alu_op, alu_tag, alu_a, alu_b,
           res_full, res_empty, occupancy
  );
endinterface

// File: rtl/reservation_station_multi.sv
// Multi-entry Tomasulo reservation station: CDB operand snoop, oldest-ready issue
// selected by an age matrix, and flush for mispredict recovery.
module reservation_station_multi #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 8,
  parameter int NUM_CDB = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  reservation_station_multi_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]  busy, v1, v2;
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];
  logic [TAG_W-1:0]  q1     [DEPTH];
  logic [TAG_W-1:0]  q2     [DEPTH];
  logic [DATA_W-1:0] val1   [DEPTH];
  logic [DATA_W-1:0] val2   [DEPTH];
  // older[j][i] = 1 when entry j was allocated before entry i
  logic [DEPTH-1:0]  older  [DEPTH];

  logic              start_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [TAG_W-1:0]  alu_tag_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;

  logic [CNT_W-1:0]  count;
  logic              full, empty;
  logic [DEPTH-1:0]  ready, sel_oh;
  logic [IDX_W-1:0]  sel_idx, free_idx;
  logic              alloc_ok, issue;
  logic [DATA_W:0]   fwd1, fwd2;
  logic [DATA_W:0]   snoop1 [DEPTH];
  logic [DATA_W:0]   snoop2 [DEPTH];

  // Returns {hit, data}; scanned high to low so the lowest matching port wins.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        vld,
    input logic [NUM_CDB*TAG_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] data
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (vld[k] && tags[k*TAG_W +: TAG_W] == tag)
        res = {1'b1, data[k*DATA_W +: DATA_W]};
    end
    return res;
  endfunction

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++)
      count = count + CNT_W'(busy[i]);
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign ready = busy & v1 & v2;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i]) free_idx = IDX_W'(i);
  end

  // An entry is selected when no other ready entry is older than it.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ready[j] && older[j][i]) sel_oh[i] = 1'b0;
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sel_oh[i]) sel_idx = IDX_W'(i);
  end

  assign alloc_ok = bus.load_word & ~full & ~bus.flush;
  assign issue    = bus.alu_free & (|ready) & ~bus.flush;

  assign fwd1 = cdb_lookup(bus.rob_tag1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  assign fwd2 = cdb_lookup(bus.rob_tag2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      snoop1[i] = cdb_lookup(q1[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      snoop2[i] = cdb_lookup(q2[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= '0;
      v1        <= '0;
      v2        <= '0;
      start_q   <= 1'b0;
      alu_op_q  <= '0;
      alu_tag_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
        q1[i]     <= '0;
        q2[i]     <= '0;
        val1[i]   <= '0;
        val2[i]   <= '0;
        older[i]  <= '0;
      end
    end else begin
      start_q <= issue;
      if (issue) begin
        alu_op_q  <= op_q[sel_idx];
        alu_tag_q <= dest_q[sel_idx];
        alu_a_q   <= val1[sel_idx];
        alu_b_q   <= val2[sel_idx];
        busy[sel_idx] <= 1'b0;
      end

      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && !v1[i] && snoop1[i][DATA_W]) begin
          v1[i]   <= 1'b1;
          val1[i] <= snoop1[i][DATA_W-1:0];
        end
        if (busy[i] && !v2[i] && snoop2[i][DATA_W]) begin
          v2[i]   <= 1'b1;
          val2[i] <= snoop2[i][DATA_W-1:0];
        end
      end

      if (alloc_ok) begin
        busy[free_idx]   <= 1'b1;
        op_q[free_idx]   <= bus.control_word;
        dest_q[free_idx] <= bus.dest_tag;
        q1[free_idx]     <= bus.rob_tag1;
        q2[free_idx]     <= bus.rob_tag2;
        v1[free_idx]     <= bus.rob_v1 | fwd1[DATA_W];
        v2[free_idx]     <= bus.rob_v2 | fwd2[DATA_W];
        val1[free_idx]   <= bus.rob_v1 ? bus.src1 : fwd1[DATA_W-1:0];
        val2[free_idx]   <= bus.rob_v2 ? bus.src2 : fwd2[DATA_W-1:0];
        // Every entry already resident is older than the newcomer.
        older[free_idx]  <= '0;
        for (int j = 0; j < DEPTH; j++)
          older[j][free_idx] <= busy[j];
      end

      if (bus.flush) begin
        busy    <= '0;
        start_q <= 1'b0;
      end
    end
  end

  assign bus.start_exe = start_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_tag   = alu_tag_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.res_full  = full;
  assign bus.res_empty = empty;
  assign bus.occupancy = count;
endmodule

// File: tb/tb_reservation_station_multi.sv
// Self-checking bench for reservation_station_multi: directed scenarios plus random
// traffic checked against an in-order queue model of the station.
module tb_reservation_station_multi;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 3;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 8;
  localparam int NUM_CDB = 2;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic clk;
  logic reset;

  reservation_station_multi_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W),
                                 .OP_W(OP_W), .NUM_CDB(NUM_CDB)) bus ();

  reservation_station_multi #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W),
                              .OP_W(OP_W), .NUM_CDB(NUM_CDB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    bit                v1;
    logic [TAG_W-1:0]  q1;
    logic [DATA_W-1:0] val1;
    bit                v2;
    logic [TAG_W-1:0]  q2;
    logic [DATA_W-1:0] val2;
  } ent_t;

  // Queue order is allocation order, so the oldest entry is always at the front.
  ent_t mq[$];
  logic              e_start;
  logic [OP_W-1:0]   e_op;
  logic [TAG_W-1:0]  e_tag;
  logic [DATA_W-1:0] e_a, e_b;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic cdb_hit(input logic [TAG_W-1:0] tag, output bit hit, output logic [DATA_W-1:0] d);
    hit = 0;
    d   = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (bus.cdb_valid[k] && bus.cdb_tag[k*TAG_W +: TAG_W] == tag) begin
        hit = 1;
        d   = bus.cdb_data[k*DATA_W +: DATA_W];
        break;
      end
    end
  endtask

  task automatic model_step();
    int iss;
    bit was_full;
    bit h;
    logic [DATA_W-1:0] d;
    ent_t n;
    iss = -1;
    if (reset) begin
      mq.delete();
      e_start = 0; e_op = '0; e_tag = '0; e_a = '0; e_b = '0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    if (!bus.flush && bus.alu_free)
      foreach (mq[i]) if (iss < 0 && mq[i].v1 && mq[i].v2) iss = i;
    e_start = (iss >= 0);
    if (iss >= 0) begin
      e_op = mq[iss].op; e_tag = mq[iss].dest; e_a = mq[iss].val1; e_b = mq[iss].val2;
    end
    foreach (mq[i]) begin
      if (!mq[i].v1) begin
        cdb_hit(mq[i].q1, h, d);
        if (h) begin mq[i].v1 = 1; mq[i].val1 = d; end
      end
      if (!mq[i].v2) begin
        cdb_hit(mq[i].q2, h, d);
        if (h) begin mq[i].v2 = 1; mq[i].val2 = d; end
      end
    end
    if (iss >= 0) mq.delete(iss);
    if (bus.flush) mq.delete();
    else if (bus.load_word && !was_full) begin
      n.op = bus.control_word; n.dest = bus.dest_tag;
      n.v1 = bus.rob_v1; n.q1 = bus.rob_tag1; n.val1 = bus.src1;
      n.v2 = bus.rob_v2; n.q2 = bus.rob_tag2; n.val2 = bus.src2;
      if (!n.v1) begin cdb_hit(n.q1, h, d); if (h) begin n.v1 = 1; n.val1 = d; end end
      if (!n.v2) begin cdb_hit(n.q2, h, d); if (h) begin n.v2 = 1; n.val2 = d; end end
      mq.push_back(n);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0;
    bus.flush = 0; bus.load_word = 0; bus.control_word = '0; bus.dest_tag = '0;
    bus.src1 = '0; bus.rob_v1 = 0; bus.rob_tag1 = '0;
    bus.src2 = '0; bus.rob_v2 = 0; bus.rob_tag2 = '0;
    bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_data = '0; bus.alu_free = 0;
  endtask

  task automatic alloc_in(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dest,
                          input logic rv1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] s1,
                          input logic rv2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] s2);
    bus.load_word = 1; bus.control_word = op; bus.dest_tag = dest;
    bus.rob_v1 = rv1; bus.rob_tag1 = t1; bus.src1 = s1;
    bus.rob_v2 = rv2; bus.rob_tag2 = t2; bus.src2 = s2;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    step();
    n_checks++; if (bus.start_exe !== 1'b0) $display("FAIL reset_start: got %0b want 0", bus.start_exe); else n_pass++;
    n_checks++; if ({bus.alu_op, bus.alu_tag, bus.alu_a, bus.alu_b} !== '0)
      $display("FAIL reset_alu: got op=%0h tag=%0d a=%0h b=%0h want all 0", bus.alu_op, bus.alu_tag, bus.alu_a, bus.alu_b);
    else n_pass++;
    n_checks++; if (bus.res_empty !== 1'b1) $display("FAIL reset_empty: got %0b want 1", bus.res_empty); else n_pass++;
    n_checks++; if (bus.res_full !== 1'b0) $display("FAIL reset_full: got %0b want 0", bus.res_full); else n_pass++;
    n_checks++; if (bus.occupancy !== CNT_W'(0)) $display("FAIL reset_occ: got %0d want 0", bus.occupancy); else n_pass++;
    reset = 0;
  endtask

  task automatic test_ready_alloc();
    do_reset();
    bus.alu_free = 1;
    alloc_in(8'h21, 3'd2, 1, 3'd0, 32'd5, 1, 3'd0, 32'd7);
    step();
    bus.load_word = 0;
    n_checks++; if (bus.res_empty !== 1'b0) $display("FAIL ready_alloc_empty: got %0b want 0", bus.res_empty); else n_pass++;
    n_checks++; if (bus.start_exe !== 1'b0) $display("FAIL ready_alloc_early: got %0b want 0", bus.start_exe); else n_pass++;
    step();
    n_checks++; if ({bus.start_exe, bus.alu_a, bus.alu_b, bus.alu_tag, bus.alu_op} !== {1'b1, 32'd5, 32'd7, 3'd2, 8'h21})
      $display("FAIL ready_alloc_issue: got start=%0b a=%0d b=%0d tag=%0d op=%0h want 1 5 7 2 21",
               bus.start_exe, bus.alu_a, bus.alu_b, bus.alu_tag, bus.alu_op);
    else n_pass++;
    n_checks++; if (bus.res_empty !== 1'b1) $display("FAIL ready_alloc_empty_after: got %0b want 1", bus.res_empty); else n_pass++;
    step();
    n_checks++; if (bus.start_exe !== 1'b0) $display("FAIL ready_alloc_pulse: got %0b want 0", bus.start_exe); else n_pass++;
  endtask

  task automatic test_cdb_wake();
    do_reset();
    bus.alu_free = 1;
    alloc_in(8'h33, 3'd3, 0, 3'd4, 32'd0, 1, 3'd0, 32'd3);
    step();
    bus.load_word = 0;
    step();
    bus.cdb_valid = 2'b01; bus.cdb_tag = {3'd0, 3'd4}; bus.cdb_data = {32'd0, 32'h11};
    step();
    bus.cdb_valid = '0;
    n_checks++; if (bus.start_exe !== 1'b0) $display("FAIL cdb_wake_same_cycle: got %0b want 0", bus.start_exe); else n_pass++;
    step();
    n_checks++; if ({bus.start_exe, bus.alu_a, bus.alu_b, bus.alu_tag} !== {1'b1, 32'h11, 32'd3, 3'd3})
      $display("FAIL cdb_wake_issue: got start=%0b a=%0h b=%0h tag=%0d want 1 11 3 3",
               bus.start_exe, bus.alu_a, bus.alu_b, bus.alu_tag);
    else n_pass++;
  endtask

  task automatic test_oldest_first();
    do_reset();
    alloc_in(8'h10, 3'd0, 1, 3'd0, 32'd100, 1, 3'd0, 32'd200); step();
    alloc_in(8'h11, 3'd1, 0, 3'd6, 32'd0,   1, 3'd0, 32'd201); step();
    alloc_in(8'h12, 3'd2, 1, 3'd0, 32'd102, 0, 3'd6, 32'd0);   step();
    alloc_in(8'h13, 3'd3, 1, 3'd0, 32'd103, 1, 3'd0, 32'd203); step();
    bus.load_word = 0;
    n_checks++; if ({bus.res_full, bus.occupancy} !== {1'b1, CNT_W'(4)})
      $display("FAIL oldest_fill: got full=%0b occ=%0d want 1 4", bus.res_full, bus.occupancy);
    else n_pass++;
    bus.cdb_valid = 2'b01; bus.cdb_tag = {3'd0, 3'd6}; bus.cdb_data = {32'd0, 32'h66};
    step();
    bus.cdb_valid = '0;
    n_checks++; if (bus.start_exe !== 1'b0) $display("FAIL oldest_held: got %0b want 0", bus.start_exe); else n_pass++;
    bus.alu_free = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if ({bus.start_exe, bus.alu_tag, bus.alu_op} !== {1'b1, 3'(k), 8'(8'h10 + k)})
        $display("FAIL oldest_order_%0d: got start=%0b tag=%0d op=%0h want 1 %0d %0h",
                 k, bus.start_exe, bus.alu_tag, bus.alu_op, k, 8'h10 + k);
      else n_pass++;
    end
    n_checks++; if ((bus.alu_a !== 32'd103) || (e_a !== 32'd103))
      $display("FAIL oldest_last_a: got %0d want 103", bus.alu_a);
    else n_pass++;
  endtask

  task automatic test_full_backpressure();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      alloc_in(8'(8'h40 + k), 3'(k), 0, 3'(k + 4), 32'd0, 1, 3'd0, 32'(k));
      step();
    end
    alloc_in(8'h55, 3'd5, 1, 3'd0, 32'd55, 1, 3'd0, 32'd56);
    step();
    n_checks++; if ({bus.res_full, bus.occupancy, bus.start_exe} !== {1'b1, CNT_W'(4), 1'b0})
      $display("FAIL full_refuse: got full=%0b occ=%0d start=%0b want 1 4 0", bus.res_full, bus.occupancy, bus.start_exe);
    else n_pass++;
    bus.cdb_valid = 2'b01; bus.cdb_tag = {3'd0, 3'd4}; bus.cdb_data = {32'd0, 32'h44};
    step();
    bus.cdb_valid = '0;
    bus.alu_free = 1;
    alloc_in(8'h55, 3'd5, 0, 3'd7, 32'd0, 1, 3'd0, 32'd56);
    step();
    n_checks++; if ({bus.start_exe, bus.alu_tag, bus.alu_a, bus.occupancy} !== {1'b1, 3'd0, 32'h44, CNT_W'(3)})
      $display("FAIL full_issue_refuse: got start=%0b tag=%0d a=%0h occ=%0d want 1 0 44 3",
               bus.start_exe, bus.alu_tag, bus.alu_a, bus.occupancy);
    else n_pass++;
    step();
    n_checks++; if ({bus.occupancy, bus.res_full, bus.start_exe} !== {CNT_W'(4), 1'b1, 1'b0})
      $display("FAIL full_retry: got occ=%0d full=%0b start=%0b want 4 1 0", bus.occupancy, bus.res_full, bus.start_exe);
    else n_pass++;
    idle();
    bus.flush = 1;
    step();
    bus.flush = 0;
  endtask

  task automatic test_forward();
    do_reset();
    bus.alu_free = 1;
    alloc_in(8'h77, 3'd1, 0, 3'd3, 32'd0, 0, 3'd3, 32'd0);
    bus.cdb_valid = 2'b10; bus.cdb_tag = {3'd3, 3'd5}; bus.cdb_data = {32'h99, 32'h44};
    step();
    bus.load_word = 0; bus.cdb_valid = '0;
    step();
    n_checks++; if ({bus.start_exe, bus.alu_a, bus.alu_b} !== {1'b1, 32'h99, 32'h99})
      $display("FAIL forward_port1: got start=%0b a=%0h b=%0h want 1 99 99", bus.start_exe, bus.alu_a, bus.alu_b);
    else n_pass++;
    alloc_in(8'h78, 3'd2, 0, 3'd3, 32'd0, 1, 3'd0, 32'd8);
    bus.cdb_valid = 2'b11; bus.cdb_tag = {3'd3, 3'd3}; bus.cdb_data = {32'h99, 32'h55};
    step();
    bus.load_word = 0; bus.cdb_valid = '0;
    step();
    n_checks++; if ({bus.start_exe, bus.alu_a, bus.alu_b} !== {1'b1, 32'h55, 32'd8})
      $display("FAIL forward_lowest_port: got start=%0b a=%0h b=%0h want 1 55 8", bus.start_exe, bus.alu_a, bus.alu_b);
    else n_pass++;
  endtask

  task automatic test_flush_reset();
    do_reset();
    bus.alu_free = 1;
    alloc_in(8'hA5, 3'd6, 1, 3'd0, 32'd1, 1, 3'd0, 32'd2);
    step();
    bus.load_word = 0;
    step();
    bus.alu_free = 0;
    for (int k = 1; k <= 3; k++) begin
      alloc_in(8'(k), 3'(k), 1, 3'd0, 32'(k), 1, 3'd0, 32'(k));
      step();
    end
    n_checks++; if (bus.occupancy !== CNT_W'(3)) $display("FAIL flush_pre_occ: got %0d want 3", bus.occupancy); else n_pass++;
    bus.flush = 1; bus.alu_free = 1;
    alloc_in(8'hEE, 3'd7, 1, 3'd0, 32'd9, 1, 3'd0, 32'd9);
    step();
    bus.flush = 0; bus.load_word = 0;
    n_checks++; if ({bus.occupancy, bus.res_empty, bus.res_full, bus.start_exe} !== {CNT_W'(0), 1'b1, 1'b0, 1'b0})
      $display("FAIL flush_state: got occ=%0d empty=%0b full=%0b start=%0b want 0 1 0 0",
               bus.occupancy, bus.res_empty, bus.res_full, bus.start_exe);
    else n_pass++;
    n_checks++; if ({bus.alu_tag, bus.alu_op} !== {3'd6, 8'hA5})
      $display("FAIL flush_alu_hold: got tag=%0d op=%0h want 6 a5", bus.alu_tag, bus.alu_op);
    else n_pass++;
    step();
    n_checks++; if ({bus.occupancy, bus.start_exe} !== {CNT_W'(0), 1'b0})
      $display("FAIL flush_after: got occ=%0d start=%0b want 0 0", bus.occupancy, bus.start_exe);
    else n_pass++;
    bus.alu_free = 0;
    for (int k = 1; k <= 3; k++) begin
      alloc_in(8'(k), 3'(k), 1, 3'd0, 32'(k), 1, 3'd0, 32'(k));
      step();
    end
    reset = 1; bus.alu_free = 1;
    step();
    reset = 0; bus.load_word = 0;
    n_checks++; if ({bus.occupancy, bus.res_empty, bus.res_full, bus.start_exe} !== {CNT_W'(0), 1'b1, 1'b0, 1'b0})
      $display("FAIL midreset_state: got occ=%0d empty=%0b full=%0b start=%0b want 0 1 0 0",
               bus.occupancy, bus.res_empty, bus.res_full, bus.start_exe);
    else n_pass++;
    n_checks++; if ({bus.alu_op, bus.alu_tag, bus.alu_a, bus.alu_b} !== '0)
      $display("FAIL midreset_alu: got op=%0h tag=%0d a=%0h b=%0h want all 0", bus.alu_op, bus.alu_tag, bus.alu_a, bus.alu_b);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset          = ($urandom_range(0, 99) == 0);
      bus.flush      = ($urandom_range(0, 39) == 0);
      bus.load_word  = ($urandom_range(0, 2) != 0);
      bus.control_word = OP_W'($urandom);
      bus.dest_tag   = TAG_W'($urandom);
      bus.src1       = $urandom;
      bus.rob_v1     = ($urandom_range(0, 2) != 0);
      bus.rob_tag1   = TAG_W'($urandom);
      bus.src2       = $urandom;
      bus.rob_v2     = ($urandom_range(0, 2) != 0);
      bus.rob_tag2   = TAG_W'($urandom);
      bus.cdb_valid  = NUM_CDB'($urandom);
      bus.cdb_tag    = (NUM_CDB*TAG_W)'($urandom);
      bus.cdb_data   = {$urandom, $urandom};
      bus.alu_free   = ($urandom_range(0, 3) != 0);
      step();
      n_checks++; if (bus.start_exe !== e_start)
        $display("FAIL rand_start c=%0d: got %0b want %0b", c, bus.start_exe, e_start);
      else n_pass++;
      n_checks++; if ({bus.alu_op, bus.alu_tag, bus.alu_a, bus.alu_b} !== {e_op, e_tag, e_a, e_b})
        $display("FAIL rand_alu c=%0d: got op=%0h tag=%0d a=%0h b=%0h want op=%0h tag=%0d a=%0h b=%0h",
                 c, bus.alu_op, bus.alu_tag, bus.alu_a, bus.alu_b, e_op, e_tag, e_a, e_b);
      else n_pass++;
      n_checks++; if ({bus.occupancy, bus.res_full, bus.res_empty} !==
                      {CNT_W'(mq.size()), mq.size() == DEPTH, mq.size() == 0})
        $display("FAIL rand_status c=%0d: got occ=%0d full=%0b empty=%0b want occ=%0d",
                 c, bus.occupancy, bus.res_full, bus.res_empty, mq.size());
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_ready_alloc();
    test_cdb_wake();
    test_oldest_first();
    test_full_backpressure();
    test_forward();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/reservation_station_multi.md
Name: reservation_station_multi

Overview:
- Parametrised successor to the single-entry ALU reservation station in the Tomasulo core.
- Holds up to DEPTH decoded instructions waiting on source operands.
- Snoops NUM_CDB common-data-bus ports to capture operands as they are produced.
- Issues the oldest ready entry to one functional unit when that unit is free; adds flush for mispredict recovery.

Parameters:
- DEPTH, 4: number of entries, power of two, 2..16.
- TAG_W, 3: ROB tag width.
- DATA_W, 32: operand width.
- OP_W, 8: opaque control-word width, carried unmodified.
- NUM_CDB, 1: number of CDB broadcast ports, 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (mispredict recovery).
- load_word  in  1  allocate request for a new instruction.
- control_word  in  OP_W  operation/control bits of the new instruction.
- dest_tag  in  TAG_W  ROB tag of the new instruction's result.
- src1  in  DATA_W  operand 1 value; valid when rob_v1=1.
- rob_v1  in  1  1 = src1 holds a value; 0 = waiting on rob_tag1.
- rob_tag1  in  TAG_W  producer tag for operand 1.
- src2  in  DATA_W  operand 2 value.
- rob_v2  in  1  operand 2 valid.
- rob_tag2  in  TAG_W  producer tag for operand 2.
- cdb_valid  in  NUM_CDB  per-port broadcast valid.
- cdb_tag  in  NUM_CDB*TAG_W  per-port tag; port k in bits [k*TAG_W +: TAG_W].
- cdb_data  in  NUM_CDB*DATA_W  per-port value; port k in bits [k*DATA_W +: DATA_W].
- alu_free  in  1  functional unit can accept an instruction this cycle.
- start_exe  out  1  registered one-cycle issue pulse.
- alu_op  out  OP_W  issued control word.
- alu_tag  out  TAG_W  issued dest tag.
- alu_a  out  DATA_W  issued operand 1.
- alu_b  out  DATA_W  issued operand 2.
- res_full  out  1  all entries busy.
- res_empty  out  1  no entries busy.
- occupancy  out  $clog2(DEPTH)+1  busy-entry count.

Behaviour:
- Reset (sync, active-high):
  - All entries cleared.
  - start_exe=0; alu_op, alu_tag, alu_a, alu_b = 0.
  - res_full=0, res_empty=1, occupancy=0.
- Entry state: busy, op, dest, v1/q1/val1, v2/q2/val2, plus an age-matrix row.
- res_full, res_empty and occupancy are derived from registered busy bits only, never from same-cycle events.
- Allocation:
  - Occurs when load_word=1, res_full=0 and flush=0.
  - New instruction is written into the lowest-index free entry at the next edge.
  - load_word while res_full=1 is ignored; no state change; the upstream stage must hold.
- Allocation-cycle forwarding:
  - If an incoming operand has rob_vX=0 and some cdb_valid[k]=1 with cdb_tag[k]=rob_tagX in the same cycle, the entry is written with that operand already valid and val = cdb_data[k].
- CDB snoop:
  - Each busy entry with vX=0 and qX matching a valid CDB port latches that port's data and sets vX=1 at the edge.
  - Both operands may wake in the same cycle.
  - If several ports match the same tag, the lowest port index wins.
- Ready rule: entry is ready when busy and v1 and v2, evaluated on registered state. An operand woken by the CDB at edge N makes its entry issuable in the cycle after edge N, never the same cycle.
- Issue:
  - When alu_free=1 and at least one entry is ready, the oldest ready entry is selected.
  - Oldest = allocated earliest, tracked by the age matrix.
  - At the edge, its fields are registered onto alu_*, start_exe=1 for exactly that cycle, and the entry is freed.
  - When there is no issue: start_exe=0 and alu_* hold their last values.
- Simultaneous events in one cycle:
  - Allocation, issue and CDB snoop may all occur together.
  - When full, allocation is still refused even if an issue frees an entry that cycle.
  - A freed slot is reusable from the next cycle.
- Occupancy update: occupancy_next = occupancy + alloc − issue, range 0..DEPTH.
- Flush:
  - At the edge, all busy bits are cleared and start_exe=0.
  - Flush beats allocation and issue in the same cycle.
  - Outputs after the edge equal their reset values, except alu_op, alu_tag, alu_a and alu_b, which hold.
- Reset asserted mid-operation: identical to power-on reset at the next edge; pending CDB data is lost.
- Tags are opaque. Tag 0 is a legal tag; there is no reserved value.

Test Plan:
- Ready alloc: load_word with rob_v1=rob_v2=1, src1=5, src2=7, dest_tag=2, alu_free=1 -> res_empty=0 after edge 1; start_exe=1 after edge 2 with alu_a=5, alu_b=7, alu_tag=2; res_empty=1 again.
- CDB wake: alloc with rob_v1=0, rob_tag1=4, src2=3 valid; broadcast tag 4 / data 0x11 two cycles later -> start_exe one cycle after the broadcast edge, alu_a=0x11, alu_b=3.
- Oldest first: fill DEPTH=4 with tags 0,1,2,3, entries 2 and 1 waiting on tag 6; broadcast tag 6 with alu_free=0; then raise alu_free -> issue order 0,1,2,3 over four consecutive cycles.
- Full back-pressure: fill 4 entries, all waiting; load_word with dest_tag=5 -> res_full=1, occupancy=4, tag 5 never issues. Wake one entry; an issue and a load in the same cycle -> load still refused; retry next cycle accepted.
- Same-cycle forward with NUM_CDB=2: alloc with rob_tag1=3, rob_tag2=3 while cdb port 1 broadcasts tag 3 / data 0x99 -> issue next cycle with alu_a=alu_b=0x99.
- Flush: 3 entries busy, flush together with load_word -> next cycle occupancy=0, res_empty=1, no start_exe. Repeat with reset instead of flush -> identical result.
